rr_pkt_arbiter: RTL and testbench

RR_PKT_ARBITER -- requirements
Module: rr_pkt_arbiter

---
 rtl/rr_pkt_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_rr_pkt_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// rr_pkt_arbiter
//
// Packet arbiter between three source channels and one formatter. While
// IDLE, and while the formatter asks for a new packet, the arbiter grants
// the requesting channel with the numerically lowest priority. It then
// stays in XFER and forwards that channel's beats until the number of
// beats given by the latched packet-length code has been accepted.
//
// Handshake: a beat moves when a2f_val_o=1 and f2a_ack_i=1 in the same
// cycle. Valid and ack are level signals. The ack is forwarded to the
// granted source only, and a beat is counted only on that cycle.
//
// Build option:
//   ARB_RR_EN  defined   : among channels tied on priority, the winner is
//                          the first one found by searching upward from
//                          (pointer+1) mod 3. The pointer becomes the last
//                          granted channel when its packet ends.
//              undefined : the lowest tied channel index wins. No pointer
//                          exists.
//
// Ports:
//   clk_i             clock, rising edge
//   rstn_i            asynchronous reset, active low
//   prio_i[5:0]       per-channel 2-bit priority, lower value wins
//   pkglen_i[8:0]     per-channel 3-bit packet-length code
//   req_i[2:0]        per-channel packet request
//   val_i[2:0]        per-channel data valid
//   data_i[3*DW-1:0]  per-channel data
//   ack_o[2:0]        per-channel data accepted
//   f2a_id_req_i      formatter ready for a new packet
//   f2a_ack_i         formatter accepts the current beat
//   a2f_val_o         beat valid to the formatter
//   a2f_id_o[1:0]     granted channel, 2'b11 when none
//   a2f_data_o[DW-1:0] beat data, all ones when idle
//   a2f_pkglen_sel_o[2:0] latched packet-length code
//   busy_o            a packet grant is held (state is XFER)
// ---------------------------------------------------------------------------
module rr_pkt_arbiter #(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [5:0]      prio_i,
  input  logic [8:0]      pkglen_i,
  input  logic [2:0]      req_i,
  input  logic [2:0]      val_i,
  input  logic [3*DW-1:0] data_i,
  output logic [2:0]      ack_o,
  input  logic            f2a_id_req_i,
  input  logic            f2a_ack_i,
  output logic            a2f_val_o,
  output logic [1:0]      a2f_id_o,
  output logic [DW-1:0]   a2f_data_o,
  output logic [2:0]      a2f_pkglen_sel_o,
  output logic            busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic [1:0] ID_NONE = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       id_q, id_d;
  logic [2:0]       len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef ARB_RR_EN
  logic [1:0]       ptr_q, ptr_d;
`endif

  // Per-channel views of the packed input buses.
  logic [1:0]    prio_a [3];
  logic [2:0]    len_a  [3];
  logic [DW-1:0] data_a [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      prio_a[i] = prio_i[2*i +: 2];
      len_a[i]  = pkglen_i[3*i +: 3];
      data_a[i] = data_i[DW*i +: DW];
    end
  end

  // The count of the final beat of a packet, from its length code.
  // Codes 3 to 7 all mean 32 beats.
  function automatic logic [CNT_W-1:0] last_beat(input logic [2:0] code);
    case (code)
      3'd0:    last_beat = CNT_W'(3);
      3'd1:    last_beat = CNT_W'(7);
      3'd2:    last_beat = CNT_W'(15);
      default: last_beat = CNT_W'(31);
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Arbitration: find the best priority among requesters, then pick one of
  // the channels that hold it.
  // -------------------------------------------------------------------------
  logic [1:0] min_prio;
  logic       seen;
  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;

  always_comb begin
    min_prio = 2'b11;
    seen     = 1'b0;
    found    = 1'b0;
    winner   = 2'd0;
    idx      = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (req_i[i] && (!seen || prio_a[i] < min_prio)) begin
        min_prio = prio_a[i];
        seen     = 1'b1;
      end
    end
`ifdef ARB_RR_EN
    // Search starts one past the last granted channel, so that channel
    // is the last one considered.
    for (int k = 1; k <= 3; k++) begin
      idx = 2'((int'(ptr_q) + k) % 3);
      if (!found && req_i[idx] && prio_a[idx] == min_prio) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`else
    for (int i = 0; i < 3; i++) begin
      idx = 2'(i);
      if (!found && req_i[idx] && prio_a[idx] == min_prio) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Datapath outputs. They come from the registered grant, so an
  // asynchronous reset clears them at once.
  // -------------------------------------------------------------------------
  logic beat;

  always_comb begin
    a2f_val_o  = 1'b0;
    a2f_data_o = '1;
    ack_o      = 3'b000;
    if (state_q == XFER) begin
      a2f_val_o   = val_i[id_q];
      a2f_data_o  = data_a[id_q];
      ack_o[id_q] = f2a_ack_i;
    end
  end

  assign beat             = a2f_val_o & f2a_ack_i;
  assign a2f_id_o         = id_q;
  assign a2f_pkglen_sel_o = len_q;
  assign busy_o           = (state_q == XFER);

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifdef ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (f2a_id_req_i && (req_i != 3'b000)) begin
          state_d = XFER;
          id_d    = winner;
          len_d   = len_a[winner];
          cnt_d   = '0;
        end
      end
      XFER: begin
        // The grant is held until the beat count completes. Request,
        // priority, length code and the formatter's id request are all
        // ignored here.
        if (beat) begin
          if (cnt_q == last_beat(len_q)) begin
            state_d = IDLE;
            id_d    = ID_NONE;
            cnt_d   = '0;
`ifdef ARB_RR_EN
            ptr_d   = id_q;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        id_d    = ID_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      id_q    <= ID_NONE;
      len_q   <= 3'b000;
      cnt_q   <= '0;
`ifdef ARB_RR_EN
      ptr_q   <= 2'd2;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
`ifdef ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_pkt_arbiter
//
// Drives packets through rr_pkt_arbiter and checks every cycle against a
// reference model in the bench. The model keeps the arbitration rule
// (best priority, then the tie rule), the packet beat counts, and a queue
// of the beats it expects on a2f_data_o. Inputs change 1 time unit after
// the rising edge. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rr_pkt_arbiter;

  localparam int DW = 32;

  logic            clk_i;
  logic            rstn_i;
  logic [5:0]      prio_i;
  logic [8:0]      pkglen_i;
  logic [2:0]      req_i;
  logic [2:0]      val_i;
  logic [3*DW-1:0] data_i;
  logic [2:0]      ack_o;
  logic            f2a_id_req_i;
  logic            f2a_ack_i;
  logic            a2f_val_o;
  logic [1:0]      a2f_id_o;
  logic [DW-1:0]   a2f_data_o;
  logic [2:0]      a2f_pkglen_sel_o;
  logic            busy_o;

  rr_pkt_arbiter #(.DW(DW), .CNT_W(6)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .prio_i           (prio_i),
    .pkglen_i         (pkglen_i),
    .req_i            (req_i),
    .val_i            (val_i),
    .data_i           (data_i),
    .ack_o            (ack_o),
    .f2a_id_req_i     (f2a_id_req_i),
    .f2a_ack_i        (f2a_ack_i),
    .a2f_val_o        (a2f_val_o),
    .a2f_id_o         (a2f_id_o),
    .a2f_data_o       (a2f_data_o),
    .a2f_pkglen_sel_o (a2f_pkglen_sel_o),
    .busy_o           (busy_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  int model_ptr = 2;
  int grant_log[$];

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Tie-break reference: collect every requester holding the best
  // priority, then choose from that list by the configured tie rule.
  function automatic int model_winner(input logic [2:0] req, input logic [5:0] prio);
    int best;
    int tied[$];
    best = 4;
    for (int c = 0; c < 3; c++)
      if (req[c] && int'(prio[2*c +: 2]) < best) best = int'(prio[2*c +: 2]);
    for (int c = 0; c < 3; c++)
      if (req[c] && int'(prio[2*c +: 2]) == best) tied.push_back(c);
`ifdef ARB_RR_EN
    foreach (tied[t]) if (tied[t] > model_ptr) return tied[t];
`endif
    return tied[0];
  endfunction

  function automatic int beats_of(input int code);
    return (code >= 3) ? 32 : (4 << code);
  endfunction

  task automatic drive_random_data();
    for (int c = 0; c < 3; c++) data_i[DW*c +: DW] = $urandom;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, 64'(busy_o), 64'd0);
    check_val({tag, "_id"},   64'(a2f_id_o), 64'd3);
    check_val({tag, "_val"},  64'(a2f_val_o), 64'd0);
    check_val({tag, "_ack"},  64'(ack_o), 64'd0);
    check_val({tag, "_data"}, 64'(a2f_data_o), 64'(32'hFFFF_FFFF));
  endtask

  // ---------------- driver ----------------
  // Entry and exit: 1 unit after a rising edge, with the DUT in IDLE.
  // stall    : randomise the granted valid and the formatter ack
  // mutate_at: from this beat onward, scramble req/prio/pkglen (-1 = never)
  // abort_at : pulse reset once this many beats are in (0 = never)
  task automatic run_packet(input logic [2:0] req, input logic [5:0] prio,
                            input logic [8:0] lens, input bit stall,
                            input int mutate_at, input int abort_at);
    int g, code, beats, n, acc;
    logic [2:0] v;
    logic a;
    req_i = req; prio_i = prio; pkglen_i = lens;
    f2a_id_req_i = 1'b0;
    val_i = 3'($urandom); f2a_ack_i = 1'($urandom);
    drive_random_data();
    @(negedge clk_i); check_idle("hold");
    @(posedge clk_i); #1;
    check_idle("no_id_req");
    f2a_id_req_i = 1'b1;
    g = model_winner(req, prio);
    code = int'(lens[3*g +: 3]);
    beats = beats_of(code);
    @(negedge clk_i); check_val("arb_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1;
    grant_log.push_back(int'(a2f_id_o));
    check_val("grant_id", 64'(a2f_id_o), 64'(g));
    check_val("grant_len", 64'(a2f_pkglen_sel_o), 64'(lens[3*g +: 3]));
    n = 0; acc = 0;
    while (1) begin
      f2a_id_req_i = 1'($urandom);
      if (mutate_at >= 0 && n >= mutate_at) begin
        req_i = 3'($urandom); prio_i = 6'($urandom); pkglen_i = 9'($urandom);
      end
      v = 3'($urandom); a = 1'($urandom);
      if (!stall) begin v[g] = 1'b1; a = 1'b1; end
      val_i = v; f2a_ack_i = a;
      drive_random_data();
      if (v[g] && a) exp_q.push_back(data_i[DW*g +: DW]);
      @(negedge clk_i);
      check_val("x_busy", 64'(busy_o), 64'd1);
      check_val("x_id", 64'(a2f_id_o), 64'(g));
      check_val("x_len", 64'(a2f_pkglen_sel_o), 64'(code));
      check_val("x_val", 64'(a2f_val_o), 64'(v[g]));
      check_val("x_ack", 64'(ack_o), 64'(3'(a) << g));
      if (v[g] && a) begin
        check_val("x_data", 64'(a2f_data_o), 64'(exp_q.pop_front()));
        n++;
      end
      if (a2f_val_o && ack_o[g]) acc++;
      if (abort_at > 0 && n == abort_at) begin
        #1 rstn_i = 1'b0;
        #1;
        check_idle("rst_mid");
        check_val("rst_len", 64'(a2f_pkglen_sel_o), 64'd0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        model_ptr = 2;
        return;
      end
      @(posedge clk_i); #1;
      if (n == beats) break;
    end
    check_val("end_busy", 64'(busy_o), 64'd0);
    check_val("end_id", 64'(a2f_id_o), 64'd3);
    check_val("end_len_held", 64'(a2f_pkglen_sel_o), 64'(code));
    check_val("accepted_beats", 64'(acc), 64'(beats));
    model_ptr = g;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] r;
    rstn_i = 1'b0;
    prio_i = '0; pkglen_i = '0; req_i = '0; val_i = '0; data_i = '0;
    f2a_id_req_i = 1'b0; f2a_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 req_i = 3'b111; f2a_id_req_i = 1'b1; val_i = 3'b111; f2a_ack_i = 1'b1;
    @(negedge clk_i);
    check_idle("reset");
    check_val("reset_len", 64'(a2f_pkglen_sel_o), 64'd0);
    @(posedge clk_i); #1;
    check_val("reset_held_id", 64'(a2f_id_o), 64'd3);
    rstn_i = 1'b1;
    f2a_id_req_i = 1'b0;

    // Single request on channel 1, 4 beats.
    run_packet(3'b010, 6'b00_00_00, 9'b000_000_000, 1'b0, -1, 0);
    // Priority: ch0=2, ch1=0, ch2=1 -> channel 1.
    run_packet(3'b111, 6'b01_00_10, 9'b000_000_000, 1'b0, -1, 0);
    check_val("prio_winner", 64'(grant_log[grant_log.size()-1]), 64'd1);
    // Reset at beat 5 of a code-2 packet. After it the pointer is back to 2.
    run_packet(3'b001, 6'b00_00_00, 9'b010_010_010, 1'b0, -1, 5);
    // Equal-priority ties, four back-to-back packets.
    grant_log.delete();
    repeat (4) run_packet(3'b111, 6'b00_00_00, 9'b000_000_000, 1'b0, -1, 0);
`ifdef ARB_RR_EN
    check_val("rr_order", 64'({grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0], grant_log[3][3:0]}), 64'h0120);
`else
    check_val("tie_order", 64'({grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0], grant_log[3][3:0]}), 64'h0000);
`endif
    // Stall: code 1 with random valid/ack.
    run_packet(3'b100, 6'b00_00_00, 9'b001_001_001, 1'b1, -1, 0);
    // Inputs changed from beat 3 of a code-2 packet.
    run_packet(3'b001, 6'b11_11_00, 9'b000_000_010, 1'b0, 3, 0);

    // Random packets.
    for (int p = 0; p < 40; p++) begin
      r = 3'($urandom_range(1, 7));
      run_packet(r, 6'($urandom), 9'($urandom), 1'($urandom), $urandom_range(0, 1) ? -1 : int'($urandom_range(0, 6)), 0);
    end

    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
